// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V style control unit: a Moore state machine that sequences
// fetch, decode, address, memory, execute and writeback steps. Only the
// memory-handshake enables, the branch PC enable and the illegal-opcode pulse
// look at inputs directly; everything else is decoded from the state register.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OP,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_OP,
  output logic       RegWrite,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t r_state;
  state_t w_next;

  // Raw strobes before the reset override.
  logic w_pc_write;
  logic w_mem_write;
  logic w_ir_write;
  logic w_reg_write;
  logic w_illegal;

  // State register; the asynchronous reset parks the machine in FETCH at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; unused codes 11-15 fall to the defaults.
  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALU_OP      = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (OP)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTER;
          OP_ITYPE:     w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALU_OP  = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALU_OP  = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALU_OP     = 2'b01;
        w_pc_write = Zero;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset must kill every strobe combinationally, even an in-flight store.
  assign PCWrite       = rst_n & w_pc_write;
  assign MemWrite      = rst_n & w_mem_write;
  assign IRWrite       = rst_n & w_ir_write;
  assign RegWrite      = rst_n & w_reg_write;
  assign illegal_instr = rst_n & w_illegal;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each driven cycle pushes the
// expected state and output vector; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] OP = 7'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_OP;
  logic [3:0] state;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1110011;

  typedef struct {
    logic [3:0]  st;
    logic [13:0] outs;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_n = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_OP(ALU_OP),
    .RegWrite(RegWrite), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output vector order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALU_OP RegWrite illegal_instr
  function automatic logic [13:0] exp_out(input int st, input logic mr, input logic z, input logic [6:0] op);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, aop;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; a = 0; b = 0; aop = 0;
    case (st)
      0:  begin pcw = mr; irw = mr; rs = 2'b10; b = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; ill = !(op inside {LW, SW, RT, IT, JL, BQ}); end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin adr = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  begin rw = 1; end
      8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcw = 1; end
      10: begin a = 2'b10; aop = 2'b01; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, a, b, aop, rw, ill};
  endfunction

  // Drive one cycle of inputs just after the edge and record what the DUT must show.
  task automatic step(input int st, input logic mr, input logic z, input logic [6:0] op);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = mr;
    Zero      = z;
    OP        = op;
    e.st   = 4'(st);
    e.outs = exp_out(st, mr, z, op);
    e.id   = step_n;
    step_n++;
    sb_q.push_back(e);
  endtask

  // Pull reset low between edges and confirm the asynchronous override.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_enables"}, 32'({PCWrite, IRWrite, MemWrite, RegWrite, illegal_instr}), 32'd0);
    check_eq({tag, "_muxes"}, 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALU_OP}), 32'b0_10_00_10_00);
    @(posedge clk);
    #1;
    check_eq({tag, "_held_state"}, 32'(state), 32'd0);
    check_eq({tag, "_held_irwrite"}, 32'(IRWrite), 32'd0);
    @(negedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: one scoreboard entry retired per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq($sformatf("state_c%0d", e.id), 32'(state), 32'(e.st));
      check_eq($sformatf("outs_c%0d_st%0d", e.id, e.st),
               32'({PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALU_OP, RegWrite, illegal_instr}),
               32'(e.outs));
      $display("cycle %0d: state=%0d outs=%b", e.id, state,
               {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALU_OP, RegWrite, illegal_instr});
    end
  end

  initial begin
    reset_pulse("rst_init");
    // lw, OP scrambled outside DECODE/MEMADR to show it is ignored there
    step(0, 1, 0, LW);  step(1, 1, 0, LW);  step(2, 1, 0, LW);
    step(3, 1, 0, RT);  step(4, 1, 0, BAD);
    // sw with two wait cycles in MEMWRITE
    step(0, 1, 0, SW);  step(1, 1, 0, SW);  step(2, 1, 0, SW);
    step(5, 0, 0, LW);  step(5, 0, 0, JL);  step(5, 1, 0, SW);
    // beq taken, then not taken
    step(0, 1, 0, BQ);  step(1, 1, 0, BQ);  step(10, 1, 1, BQ);
    step(0, 1, 1, BQ);  step(1, 1, 1, BQ);  step(10, 1, 0, BQ);
    // unsupported opcode
    step(0, 1, 0, BAD); step(1, 1, 0, BAD);
    // fetch stall of three cycles, then R-type
    step(0, 0, 0, RT);  step(0, 0, 0, RT);  step(0, 0, 0, RT);  step(0, 1, 0, RT);
    step(1, 1, 0, RT);  step(6, 1, 0, RT);  step(7, 1, 0, RT);
    // I-type and jal
    step(0, 1, 0, IT);  step(1, 1, 0, IT);  step(8, 1, 0, IT);  step(7, 1, 0, IT);
    step(0, 1, 0, JL);  step(1, 1, 0, JL);  step(9, 1, 0, JL);  step(7, 1, 0, JL);
    // lw stalled in MEMREAD, then aborted by reset
    step(0, 1, 0, LW);  step(1, 1, 0, LW);  step(2, 1, 0, LW);  step(3, 0, 0, LW);
    reset_pulse("rst_memread");
    step(0, 0, 0, SW);  step(0, 1, 0, SW);  step(1, 1, 0, SW);  step(2, 1, 0, SW);
    step(5, 0, 0, SW);
    reset_pulse("rst_memwrite");
    step(0, 1, 0, IT);  step(1, 1, 0, IT);  step(8, 1, 0, IT);  step(7, 1, 0, IT);
    step(0, 0, 0, IT);
    @(negedge clk);
    #2;
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 OP  input  7  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag, valid in the BEQ state.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 PCWrite  output  1  PC load enable.
REQ-008 AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
REQ-009 MemWrite  output  1  memory write strobe.
REQ-010 IRWrite  output  1  instruction register and OldPC load enable.
REQ-011 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-013 ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-014 ALU_OP  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = decode by funct.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 illegal_instr  output  1  one-cycle pulse on an unsupported opcode.
REQ-017 state  output  4  current state encoding, for debug.

Function
REQ-018 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
REQ-019 Codes 11-15 SHALL transition to FETCH on the next edge, with all outputs at their default value (0).
REQ-020 Any output not listed for a state SHALL be 0 in that state.
REQ-021 FETCH outputs SHALL be: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU_OP=00, ResultSrc=10.
REQ-022 In FETCH, IRWrite=mem_ready and PCWrite=mem_ready.
REQ-023 FETCH SHALL go to DECODE when mem_ready=1, otherwise hold in FETCH.
REQ-024 DECODE outputs SHALL be ALUSrcA=01, ALUSrcB=01, ALU_OP=00 (branch target precompute).
REQ-025 DECODE next state SHALL be selected by OP:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other value -> FETCH, with illegal_instr=1 in this DECODE cycle only.
REQ-026 MEMADR outputs SHALL be ALUSrcA=10, ALUSrcB=01, ALU_OP=00; next state MEMREAD if OP=0000011, else MEMWRITE.
REQ-027 MEMREAD outputs SHALL be AdrSrc=1, ResultSrc=00; go to MEMWB when mem_ready=1, else hold.
REQ-028 MEMWB outputs SHALL be ResultSrc=01, RegWrite=1; next state FETCH.
REQ-029 MEMWRITE outputs SHALL be AdrSrc=1, ResultSrc=00, MemWrite=1, with MemWrite held high while waiting.
REQ-030 MEMWRITE SHALL go to FETCH when mem_ready=1, else hold.
REQ-031 EXECUTER outputs SHALL be ALUSrcA=10, ALUSrcB=00, ALU_OP=10; next state ALUWB.
REQ-032 EXECUTEI outputs SHALL be ALUSrcA=10, ALUSrcB=01, ALU_OP=10; next state ALUWB.
REQ-033 ALUWB outputs SHALL be ResultSrc=00, RegWrite=1; next state FETCH.
REQ-034 JAL outputs SHALL be ALUSrcA=01, ALUSrcB=10, ALU_OP=00, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-035 BEQ outputs SHALL be ALUSrcA=10, ALUSrcB=00, ALU_OP=01, ResultSrc=00, PCWrite=Zero; next state FETCH.
REQ-036 Outputs SHALL be combinational from the registered state. Only IRWrite, PCWrite and illegal_instr may also depend on the inputs (mem_ready, Zero, OP).
REQ-037 OP SHALL be sampled only in DECODE and MEMADR; OP changes in other states SHALL have no effect.
REQ-038 Cycle counts with mem_ready=1 throughout SHALL be:
- lw: 5
- sw: 4
- R-type and I-type: 4
- jal: 4
- beq: 3
REQ-039 Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle.

Reset
REQ-040 rst_n=0 SHALL force state=FETCH immediately, without waiting for a clock edge.
REQ-041 While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr SHALL be 0, overriding mem_ready.
REQ-042 All other outputs SHALL take their FETCH values during reset.
REQ-043 A reset asserted mid-instruction (including during MEMWRITE) SHALL abort the instruction and drop MemWrite and RegWrite within the same cycle.
REQ-044 After rst_n rises, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-045 lw (OP=0000011), mem_ready=1: state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-046 sw with mem_ready=0 for 2 cycles in MEMWRITE: state sequence 0,1,2,5,5,5,0; MemWrite=1 for exactly 3 cycles; RegWrite never 1.
REQ-047 beq, once with Zero=1 and once with Zero=0: state sequence 0,1,10,0; PCWrite=1 in state 10 only when Zero=1; ALU_OP=01.
REQ-048 OP=1110011 (unsupported): state sequence 0,1,0; illegal_instr=1 for exactly one cycle, in state 1.
REQ-049 rst_n pulled low in MEMREAD: state=0 with no clock edge; all enables 0; after release, fetch restarts with IRWrite following mem_ready.
REQ-050 FETCH with mem_ready=0 for 3 cycles, then R-type: state 0 for 4 cycles; IRWrite=1 only in the last of them; then states 1,6,7,0, with ALU_OP=10 in state 6.
